// File: rtl/msg_uart_tx.sv
// msg_uart_tx: latches a 1..MAX_BYTES message and sends it byte-by-byte as
// UART frames on txd. Supports repeat with an idle gap, and abort.
// Optional macro MSG_UART_TX_PARITY_EN adds an even-parity bit to each frame,
// giving 11 bit-times per frame instead of 10.
module msg_uart_tx #(
    parameter int unsigned CLK_HZ    = 100_000_000,
    parameter int unsigned BIT_RATE  = 9_600,
    parameter int unsigned MAX_BYTES = 16,
    parameter int unsigned GAP_BITS  = 2,
    localparam int unsigned LEN_W    = $clog2(MAX_BYTES + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [8*MAX_BYTES-1:0] msg_data,
    input  logic [LEN_W-1:0]       msg_len,
    input  logic                   repeat_en,
    input  logic                   abort,
    output logic                   txd,
    output logic                   busy,
    output logic                   byte_done,
    output logic                   msg_done,
    output logic [LEN_W-1:0]       byte_idx
);

    localparam int unsigned CPB     = CLK_HZ / BIT_RATE;
    localparam int unsigned GAP_CYC = GAP_BITS * CPB;
    localparam int unsigned CNT_MAX = (GAP_CYC > CPB) ? GAP_CYC : CPB;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int unsigned MSG_W   = 8 * MAX_BYTES;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START_BIT = 3'd1,
        DATA      = 3'd2,
        STOP_BIT  = 3'd3,
        GAP       = 3'd4
`ifdef MSG_UART_TX_PARITY_EN
        , PARITY  = 3'd5
`endif
    } state_t;

    state_t            state_q, state_n;
    logic [CNT_W-1:0]  cnt_q, cnt_n;
    logic [2:0]        bit_q, bit_n;
    logic [LEN_W-1:0]  idx_n;
    logic [LEN_W-1:0]  len_q, len_in;
    logic [MSG_W-1:0]  msg_q;
    logic [7:0]        cur_byte;
    logic              load;
    logic              bit_last;
    logic              gap_last;
    logic              last_byte;
    logic              txd_n;
    logic              byte_done_n;
    logic              msg_done_n;

    // Next-state, counters and next registered outputs
    always_comb begin
        state_n     = state_q;
        cnt_n       = cnt_q + CNT_W'(1);
        bit_n       = bit_q;
        idx_n       = byte_idx;
        load        = 1'b0;
        len_in      = (msg_len > LEN_W'(MAX_BYTES)) ? LEN_W'(MAX_BYTES) : msg_len;
        bit_last    = (cnt_q == CNT_W'(CPB - 1));
        gap_last    = (cnt_q == CNT_W'(GAP_CYC - 1));
        last_byte   = (byte_idx == len_q - LEN_W'(1));
        cur_byte    = 8'h00;
        txd_n       = 1'b1;
        byte_done_n = 1'b0;
        msg_done_n  = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_n = '0;
                idx_n = '0;
                if (start && (msg_len != '0)) begin
                    load    = 1'b1;
                    state_n = START_BIT;
                end
            end
            START_BIT: begin
                if (bit_last) begin
                    state_n = DATA;
                    cnt_n   = '0;
                    bit_n   = 3'd0;
                end
            end
            DATA: begin
                if (bit_last) begin
                    cnt_n = '0;
                    bit_n = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
`ifdef MSG_UART_TX_PARITY_EN
                        state_n = PARITY;
`else
                        state_n = STOP_BIT;
`endif
                    end
                end
            end
`ifdef MSG_UART_TX_PARITY_EN
            PARITY: begin
                if (bit_last) begin
                    state_n = STOP_BIT;
                    cnt_n   = '0;
                end
            end
`endif
            STOP_BIT: begin
                if (bit_last) begin
                    cnt_n = '0;
                    if (!last_byte) begin
                        state_n = START_BIT;
                        idx_n   = byte_idx + LEN_W'(1);
                    end else if (!repeat_en) begin
                        state_n = IDLE;
                        idx_n   = '0;
                    end else if (GAP_BITS > 0) begin
                        state_n = GAP;
                    end else begin
                        state_n = START_BIT;
                        idx_n   = '0;
                    end
                end
            end
            GAP: begin
                if (gap_last) begin
                    state_n = START_BIT;
                    cnt_n   = '0;
                    idx_n   = '0;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
                idx_n   = '0;
            end
        endcase

        // Abort wins over any in-flight transition, including the pulse cycle
        if (abort && (state_q != IDLE)) begin
            state_n = IDLE;
            cnt_n   = '0;
            bit_n   = '0;
            idx_n   = '0;
        end

        for (int unsigned i = 0; i < MAX_BYTES; i++) begin
            if (idx_n == LEN_W'(i)) cur_byte = msg_q[MSG_W-1-8*i -: 8];
        end

        case (state_n)
            START_BIT: txd_n = 1'b0;
            DATA:      txd_n = cur_byte[bit_n];
`ifdef MSG_UART_TX_PARITY_EN
            PARITY:    txd_n = ^cur_byte;
`endif
            default:   txd_n = 1'b1;
        endcase

        byte_done_n = (state_n == STOP_BIT) && (cnt_n == CNT_W'(CPB - 1));
        msg_done_n  = byte_done_n && (idx_n == len_q - LEN_W'(1));
    end

    // State, counters, message latch and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            len_q     <= '0;
            msg_q     <= '0;
            txd       <= 1'b1;
            busy      <= 1'b0;
            byte_done <= 1'b0;
            msg_done  <= 1'b0;
            byte_idx  <= '0;
        end else begin
            state_q   <= state_n;
            cnt_q     <= cnt_n;
            bit_q     <= bit_n;
            byte_idx  <= idx_n;
            txd       <= txd_n;
            busy      <= (state_n != IDLE);
            byte_done <= byte_done_n;
            msg_done  <= msg_done_n;
            if (load) begin
                msg_q <= msg_data;
                len_q <= len_in;
            end
        end
    end

endmodule

// File: tb/tb_msg_uart_tx.sv
// Testbench for msg_uart_tx: builds the expected per-cycle line waveform
// from the frame format and compares it with the DUT every cycle.
module tb_msg_uart_tx;

    localparam int unsigned CLK_HZ    = 1_000_000;
    localparam int unsigned BIT_RATE  = 100_000;
    localparam int unsigned MAX_BYTES = 4;
    localparam int unsigned GAP_BITS  = 2;
    localparam int unsigned CPB       = CLK_HZ / BIT_RATE;
    localparam int unsigned LEN_W     = $clog2(MAX_BYTES + 1);
`ifdef MSG_UART_TX_PARITY_EN
    localparam int unsigned FRAME_BITS = 11;
`else
    localparam int unsigned FRAME_BITS = 10;
`endif
    localparam int unsigned FRAME_CYC = FRAME_BITS * CPB;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   start;
    logic [8*MAX_BYTES-1:0] msg_data;
    logic [LEN_W-1:0]       msg_len;
    logic                   repeat_en;
    logic                   abort;
    logic                   txd;
    logic                   busy;
    logic                   byte_done;
    logic                   msg_done;
    logic [LEN_W-1:0]       byte_idx;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic             vld;
        logic             txd;
        logic             busy;
        logic             bd;
        logic             md;
        logic [LEN_W-1:0] idx;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] model_bytes [MAX_BYTES];
    int         model_len;

    msg_uart_tx #(
        .CLK_HZ   (CLK_HZ),
        .BIT_RATE (BIT_RATE),
        .MAX_BYTES(MAX_BYTES),
        .GAP_BITS (GAP_BITS)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .msg_data (msg_data),
        .msg_len  (msg_len),
        .repeat_en(repeat_en),
        .abort    (abort),
        .txd      (txd),
        .busy     (busy),
        .byte_done(byte_done),
        .msg_done (msg_done),
        .byte_idx (byte_idx)
    );

    always #5 clk = ~clk;

    initial begin
        #10_000_000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1);
    end

    function automatic logic [8*MAX_BYTES-1:0] pack_model();
        logic [8*MAX_BYTES-1:0] v;
        v = '0;
        for (int i = 0; i < int'(MAX_BYTES); i++) v[8*(int'(MAX_BYTES)-i)-1 -: 8] = model_bytes[i];
        return v;
    endfunction

    function automatic void randomize_model();
        for (int i = 0; i < int'(MAX_BYTES); i++) model_bytes[i] = 8'($urandom);
    endfunction

    // One pass of the message: every byte as start, 8 data bits LSB first,
    // optional even parity, stop; then an idle-high gap when repeating.
    function automatic void push_pass(input bit with_gap);
        exp_t e;
        logic bv;
        for (int b = 0; b < model_len; b++) begin
            for (int k = 0; k < int'(FRAME_BITS); k++) begin
                if (k == 0)                          bv = 1'b0;
                else if (k <= 8)                     bv = model_bytes[b][k-1];
                else if (k == int'(FRAME_BITS) - 1)  bv = 1'b1;
                else                                 bv = ^model_bytes[b];
                for (int c = 0; c < int'(CPB); c++) begin
                    e.vld  = 1'b1;
                    e.txd  = bv;
                    e.busy = 1'b1;
                    e.bd   = (k == int'(FRAME_BITS) - 1) && (c == int'(CPB) - 1);
                    e.md   = e.bd && (b == model_len - 1);
                    e.idx  = LEN_W'(b);
                    exp_q.push_back(e);
                end
            end
        end
        if (with_gap) begin
            for (int c = 0; c < int'(GAP_BITS * CPB); c++) begin
                e.vld = 1'b0; e.txd = 1'b1; e.busy = 1'b1; e.bd = 1'b0; e.md = 1'b0; e.idx = '0;
                exp_q.push_back(e);
            end
        end
    endfunction

    function automatic void push_idle(input int n);
        exp_t e;
        for (int c = 0; c < n; c++) begin
            e.vld = 1'b1; e.txd = 1'b1; e.busy = 1'b0; e.bd = 1'b0; e.md = 1'b0; e.idx = '0;
            exp_q.push_back(e);
        end
    endfunction

    function automatic void truncate_after(input int k);
        while (exp_q.size() > k + 1) void'(exp_q.pop_back());
    endfunction

    // Observed outputs; byte_idx is don't-care where the expectation says so
    function automatic logic [LEN_W+3:0] observe(input exp_t e);
        return {txd, busy, byte_done, msg_done, e.vld ? byte_idx : e.idx};
    endfunction

    // Called on a falling edge; start is seen by the next rising edge
    task automatic start_msg(input logic [8*MAX_BYTES-1:0] d, input logic [LEN_W-1:0] l,
                             input logic rep, input logic ab);
        msg_data  = d;
        msg_len   = l;
        repeat_en = rep;
        abort     = ab;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; abort = 1'b0; repeat_en = 1'b0;
        msg_data = '0; msg_len = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({txd, busy, byte_done, msg_done, byte_idx} !== {4'b1000, LEN_W'(0)}) begin
            errors++;
            $display("FAIL reset_held: got %b expected %b", {txd, busy, byte_done, msg_done, byte_idx}, {4'b1000, LEN_W'(0)});
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({txd, busy, byte_done, msg_done, byte_idx} !== {4'b1000, LEN_W'(0)}) begin
            errors++;
            $display("FAIL reset_release: got %b expected %b", {txd, busy, byte_done, msg_done, byte_idx}, {4'b1000, LEN_W'(0)});
        end
    endtask

    task automatic test_single_frame();
        randomize_model();
        model_bytes[0] = 8'h57;
        model_len = 1;
        exp_q.delete();
        push_pass(1'b0);
        push_idle(3);
        start_msg(pack_model(), LEN_W'(1), 1'b0, 1'b0);
        for (int c = 0; c < exp_q.size(); c++) begin
            checks++;
            if (observe(exp_q[c]) !== exp_q[c][LEN_W+3:0]) begin
                errors++;
                $display("FAIL single_frame cycle %0d: got %b expected %b", c, observe(exp_q[c]), exp_q[c][LEN_W+3:0]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_multi_byte();
        randomize_model();
        model_bytes[0] = 8'h4E; model_bytes[1] = 8'h65; model_bytes[2] = 8'h6F;
        model_len = 3;
        exp_q.delete();
        push_pass(1'b0);
        push_idle(3);
        start_msg(pack_model(), LEN_W'(3), 1'b0, 1'b0);
        for (int c = 0; c < exp_q.size(); c++) begin
            checks++;
            if (observe(exp_q[c]) !== exp_q[c][LEN_W+3:0]) begin
                errors++;
                $display("FAIL multi_byte cycle %0d: got %b expected %b", c, observe(exp_q[c]), exp_q[c][LEN_W+3:0]);
            end
            if (c == 150) begin
                start = 1'b1; msg_data = {MAX_BYTES{8'($urandom)}}; msg_len = LEN_W'(1);
            end else if (c == 151) begin
                start = 1'b0;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_random_msgs();
        for (int n = 0; n < 3; n++) begin
            randomize_model();
            model_len = int'($urandom_range(1, MAX_BYTES));
            exp_q.delete();
            push_pass(1'b0);
            push_idle(2);
            start_msg(pack_model(), LEN_W'(model_len), 1'b0, 1'b0);
            for (int c = 0; c < exp_q.size(); c++) begin
                checks++;
                if (observe(exp_q[c]) !== exp_q[c][LEN_W+3:0]) begin
                    errors++;
                    $display("FAIL random_msg%0d cycle %0d: got %b expected %b", n, c, observe(exp_q[c]), exp_q[c][LEN_W+3:0]);
                end
                @(negedge clk);
            end
        end
    endtask

    task automatic test_repeat();
        int pass_cyc;
        randomize_model();
        model_len = 2;
        pass_cyc = 2 * int'(FRAME_CYC);
        exp_q.delete();
        push_pass(1'b1);
        push_pass(1'b0);
        push_idle(5);
        start_msg(pack_model(), LEN_W'(2), 1'b1, 1'b0);
        for (int c = 0; c < exp_q.size(); c++) begin
            checks++;
            if (observe(exp_q[c]) !== exp_q[c][LEN_W+3:0]) begin
                errors++;
                $display("FAIL repeat cycle %0d: got %b expected %b", c, observe(exp_q[c]), exp_q[c][LEN_W+3:0]);
            end
            if (c == 30) begin
                msg_data = ~pack_model();
                msg_len  = LEN_W'(1);
            end
            if (c == pass_cyc + int'(GAP_BITS * CPB) + 30) repeat_en = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic test_len_edges();
        randomize_model();
        model_len = 0;
        exp_q.delete();
        push_idle(40);
        start_msg(pack_model(), LEN_W'(0), 1'b0, 1'b0);
        for (int c = 0; c < exp_q.size(); c++) begin
            checks++;
            if (observe(exp_q[c]) !== exp_q[c][LEN_W+3:0]) begin
                errors++;
                $display("FAIL len_zero cycle %0d: got %b expected %b", c, observe(exp_q[c]), exp_q[c][LEN_W+3:0]);
            end
            @(negedge clk);
        end
        randomize_model();
        model_len = int'(MAX_BYTES);
        exp_q.delete();
        push_pass(1'b0);
        push_idle(3);
        start_msg(pack_model(), LEN_W'(MAX_BYTES + 3), 1'b0, 1'b0);
        for (int c = 0; c < exp_q.size(); c++) begin
            checks++;
            if (observe(exp_q[c]) !== exp_q[c][LEN_W+3:0]) begin
                errors++;
                $display("FAIL len_over cycle %0d: got %b expected %b", c, observe(exp_q[c]), exp_q[c][LEN_W+3:0]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_abort();
        int k;
        // Abort during data of byte 1, then a stray abort while idle
        randomize_model();
        model_len = 2;
        k = int'(FRAME_CYC + 3 * CPB + 4);
        exp_q.delete();
        push_pass(1'b0);
        truncate_after(k);
        push_idle(10);
        start_msg(pack_model(), LEN_W'(2), 1'b0, 1'b0);
        for (int c = 0; c < exp_q.size(); c++) begin
            checks++;
            if (observe(exp_q[c]) !== exp_q[c][LEN_W+3:0]) begin
                errors++;
                $display("FAIL abort_data cycle %0d: got %b expected %b", c, observe(exp_q[c]), exp_q[c][LEN_W+3:0]);
            end
            if (c == k || c == k + 5)          abort = 1'b1;
            else if (c == k + 1 || c == k + 6) abort = 1'b0;
            @(negedge clk);
        end
        // Abort just before the final stop-bit cycle suppresses both pulses
        randomize_model();
        k = 2 * int'(FRAME_CYC) - 2;
        exp_q.delete();
        push_pass(1'b0);
        truncate_after(k);
        push_idle(5);
        start_msg(pack_model(), LEN_W'(2), 1'b0, 1'b0);
        for (int c = 0; c < exp_q.size(); c++) begin
            checks++;
            if (observe(exp_q[c]) !== exp_q[c][LEN_W+3:0]) begin
                errors++;
                $display("FAIL abort_stop cycle %0d: got %b expected %b", c, observe(exp_q[c]), exp_q[c][LEN_W+3:0]);
            end
            if (c == k)          abort = 1'b1;
            else if (c == k + 1) abort = 1'b0;
            @(negedge clk);
        end
        // Start and abort together in idle: start is accepted
        randomize_model();
        model_len = 1;
        exp_q.delete();
        push_pass(1'b0);
        push_idle(2);
        start_msg(pack_model(), LEN_W'(1), 1'b0, 1'b1);
        for (int c = 0; c < exp_q.size(); c++) begin
            checks++;
            if (observe(exp_q[c]) !== exp_q[c][LEN_W+3:0]) begin
                errors++;
                $display("FAIL start_with_abort cycle %0d: got %b expected %b", c, observe(exp_q[c]), exp_q[c][LEN_W+3:0]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid();
        int k;
        randomize_model();
        model_len = 3;
        k = int'(FRAME_CYC + 5 * CPB + 2);
        exp_q.delete();
        push_pass(1'b0);
        truncate_after(k);
        push_idle(6);
        start_msg(pack_model(), LEN_W'(3), 1'b0, 1'b0);
        for (int c = 0; c < exp_q.size(); c++) begin
            checks++;
            if (observe(exp_q[c]) !== exp_q[c][LEN_W+3:0]) begin
                errors++;
                $display("FAIL reset_mid cycle %0d: got %b expected %b", c, observe(exp_q[c]), exp_q[c][LEN_W+3:0]);
            end
            if (c == k)          reset = 1'b1;
            else if (c == k + 1) reset = 1'b0;
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_multi_byte();
        test_random_msgs();
        test_repeat();
        test_len_edges();
        test_abort();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
